alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU (ops ADD/SUB/AND/OR/FORWARD, 3-bit SELECT, combinational RESULT/ZERO with multi-ns settle).
Grants the ALU to requester 0 (main datapath) or requester 1 (branch/compare unit) using round-robin. Registers the ALU operands and holds them for a programmable settle window, then captures RESULT/ZERO. Returns them to the winner as a one-cycle response pulse.
Sits between the requesters and the single ALU instance. Drives ALU DATA1/DATA2/SELECT exclusively.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that grants a shared combinational ALU to one of two requesters and returns captured results.
// Latency: response pulse SETTLE cycles after the accept edge; one op every SETTLE+2 cycles.
// Backpressure: READY is offered only in IDLE and only to the single winning requester.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [WIDTH-1:0] REQ0_DATA1,
    input  logic [WIDTH-1:0] REQ0_DATA2,
    input  logic [2:0]       REQ0_SELECT,
    output logic             RSP0_VALID,
    output logic [WIDTH-1:0] RSP0_RESULT,
    output logic             RSP0_ZERO,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ1_DATA1,
    input  logic [WIDTH-1:0] REQ1_DATA2,
    input  logic [2:0]       REQ1_SELECT,
    output logic             RSP1_VALID,
    output logic [WIDTH-1:0] RSP1_RESULT,
    output logic             RSP1_ZERO,
    output logic [WIDTH-1:0] ALU_DATA1,
    output logic [WIDTH-1:0] ALU_DATA2,
    output logic [2:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_ZERO,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] settle_cnt;
    logic       owner;
    logic       rr_ptr;
    logic       winner;
    logic       accept;

    always_comb begin
        state_nxt  = state;
        winner     = rr_ptr;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP0_VALID = 1'b0;
        RSP1_VALID = 1'b0;
        BUSY       = (state != IDLE);

        // A lone requester wins outright; the pointer only breaks ties.
        if (REQ0_VALID && !REQ1_VALID) begin
            winner = 1'b0;
        end else if (REQ1_VALID && !REQ0_VALID) begin
            winner = 1'b1;
        end

        case (state)
            IDLE: begin
                REQ0_READY = REQ0_VALID && !winner;
                REQ1_READY = REQ1_VALID && winner;
                if (REQ0_VALID || REQ1_VALID) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt == 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                RSP0_VALID = !owner;
                RSP1_VALID = owner;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        accept = REQ0_READY || REQ1_READY;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            settle_cnt  <= 3'd0;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            ALU_DATA1   <= '0;
            ALU_DATA2   <= '0;
            ALU_SELECT  <= 3'b000;
            RSP0_RESULT <= '0;
            RSP0_ZERO   <= 1'b0;
            RSP1_RESULT <= '0;
            RSP1_ZERO   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                ALU_DATA1  <= winner ? REQ1_DATA1  : REQ0_DATA1;
                ALU_DATA2  <= winner ? REQ1_DATA2  : REQ0_DATA2;
                ALU_SELECT <= winner ? REQ1_SELECT : REQ0_SELECT;
                owner      <= winner;
                rr_ptr     <= ~winner;
                settle_cnt <= SETTLE_CNT;
            end
            if (state == EXEC) begin
                settle_cnt <= settle_cnt - 3'd1;
                // Operands have been stable on the ALU for SETTLE cycles here.
                if (settle_cnt == 3'd1) begin
                    if (owner) begin
                        RSP1_RESULT <= ALU_RESULT;
                        RSP1_ZERO   <= ALU_ZERO;
                    end else begin
                        RSP0_RESULT <= ALU_RESULT;
                        RSP0_ZERO   <= ALU_ZERO;
                    end
                end
            end
        end
    end

endmodule
